temp_overlay_renderer: RTL and testbench
========================================

TEMP_OVERLAY_RENDERER -- requirements
Module: temp_overlay_renderer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of displayed values (1..4).
REQ-002 SHALL have parameter VAL_W, default 8, meaning the width of each unsigned input value.
REQ-003 SHALL have parameter DIGITS, default 3, meaning the decimal digits shown per channel (1..4).
REQ-004 SHALL have parameters TEXT_ROW, default 5, COL0, default 6, CH_PITCH, default 30, and DIGIT_PITCH, default 6, meaning layout origin and spacing in pixels.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have these ports:
 - clk, input, 1, clock.
 - rst, input, 1, synchronous active-high reset.
 - val_in, input, NUM_CH*VAL_W, packed values; channel 0 in the LSBs.
 - val_load, input, 1, single-cycle request to snapshot val_in.
 - busy, output, 1, conversion in progress.
 - frame_tick, input, 1, one pulse per display frame.
 - pix_req, input, 1, pixel_addr is valid this cycle.
 - pixel_addr, input, 11, {row[4:0], col[5:0]}.
 - pix_valid, output, 1, pixel_data is valid.
 - pixel_data, output, 24, RGB888.

Function
REQ-007 SHALL convert values with a sequential shift-add-3 FSM with states IDLE, SHIFT, STORE and COMMIT.
 - In IDLE, a val_load snapshots val_in and moves the FSM to SHIFT for channel 0.
 - SHIFT lasts VAL_W cycles. STORE lasts 1 cycle, then the next channel's SHIFT begins, or COMMIT after the last channel.
 - COMMIT lasts 1 cycle, then the FSM returns to IDLE.
REQ-008 SHALL hold busy high from the cycle after val_load is accepted through COMMIT inclusive, for NUM_CH*(VAL_W+1)+1 cycles (19 at defaults).
REQ-009 SHALL keep displayed digits in a separate register bank that updates only in COMMIT, so pixel output never shows a partial conversion.
REQ-010 SHALL, on a val_load while busy, re-snapshot val_in into a pending register and set a pending flag.
 - After COMMIT the FSM restarts from the pending snapshot without returning to IDLE first.
 - If several loads arrive while busy, only the latest is kept.
REQ-011 SHALL saturate all digits of a channel to 9 when its value exceeds 10^DIGITS-1.
REQ-012 SHALL blank leading zeros, except that the units digit is always drawn.
REQ-013 SHALL place channel c, digit d (d=0 is the most significant) at columns COL0+c*CH_PITCH+d*DIGIT_PITCH .. +4, rows TEXT_ROW..TEXT_ROW+6.
REQ-014 SHALL draw a 2x3-pixel degree marker at column offset DIGITS*DIGIT_PITCH, font rows 0..2.
REQ-015 SHALL colour channel c with CH_COLOR[c] and draw black elsewhere; pixels outside every glyph are black.
REQ-016 SHALL have a pixel path latency of exactly 2 cycles.
 - Stage 1 registers the address decode and font row.
 - Stage 2 registers pixel_data.
 - pix_valid equals pix_req delayed by 2 cycles.
 - One request per cycle is accepted, with no stalls.
REQ-017 SHALL render the pixel path from the committed bank, unaffected by FSM activity.

Reset
REQ-018 SHALL, on rst, clear the FSM to IDLE and clear busy, pix_valid, pending, the blink counter and all pipeline registers.
REQ-019 SHALL set pixel_data to 24'h000000 on rst.
REQ-020 SHALL set the committed digits to 0, so every channel shows "0".
REQ-021 SHALL, when rst is asserted mid-conversion, discard the conversion and leave no pending load.

Configuration
REQ-022 SHALL define macro TEMP_OVERLAY_BLINK_EN and parameter ALARM_THR, default 40.
 - With the macro defined, a channel whose committed value is >= ALARM_THR is drawn black while bit 4 of a frame_tick counter is 1, i.e. 16 frames on and 16 frames off.
 - Without the macro, no counter is built, frame_tick is ignored and glyphs are always drawn.

Structure
REQ-023 SHALL place the FSM state enum, the CH_COLOR table, the glyph width/height constants (5/7) and the marker size in package overlay_pkg.
 - CH_COLOR is {FF0000, 0000FF, 00FF00, FFFF00}.
REQ-024 SHALL implement the font in one combinational sub-module, overlay_font_rom, which maps (digit[3:0], row[2:0]) to 5 pixel bits; code 15 is blank.

Verification
REQ-025 SHALL cover: val_in = {77, 25}, val_load -> busy for 19 cycles; then (row 5, col 12) is red, col 6 is black (blanked zero) and the ch1 digits read 0, 7, 7 in blue.
REQ-026 SHALL cover: val_load, then val_load again at cycle 5 with {10, 3} -> the first COMMIT, immediate restart, and final digits of 3 and 10 after 38 cycles.
REQ-027 SHALL cover: a value of 250 with DIGITS=2 -> "99" is displayed.
REQ-028 SHALL cover: a pix_req burst of 64 back-to-back addresses -> 64 pix_valid pulses, each exactly 2 cycles later, matching a reference model.
REQ-029 SHALL cover: rst asserted at cycle 7 of a conversion -> busy is 0 on the next cycle and the display shows "0".
REQ-030 SHALL cover, with TEMP_OVERLAY_BLINK_EN defined: value 45 and 32 frame_ticks -> glyph pixels are black during ticks 16..31; value 39 -> glyph pixels are never black.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types and constants for the temperature overlay renderer.
package overlay_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StStore, StCommit} conv_state_e;

  localparam int unsigned GLYPH_W = 5;
  localparam int unsigned GLYPH_H = 7;
  localparam int unsigned MARK_W  = 2;
  localparam int unsigned MARK_H  = 3;

  // Entry 0 is channel 0: red, blue, green, yellow.
  localparam logic [3:0][23:0] CH_COLOR = {24'hFFFF00, 24'h00FF00, 24'h0000FF, 24'hFF0000};

endpackage

// File: rtl/overlay_font_rom.sv
// 5x7 decimal digit font; bit 4 of bits_o is the leftmost pixel, code 15 (and 10..14) is blank.
module overlay_font_rom (
  input  logic [3:0] digit_i,
  input  logic [2:0] row_i,
  output logic [4:0] bits_o
);

  logic [7:0][4:0] glyph;

  // Glyph rows are listed from row 7 (always empty) down to row 0.
  always_comb begin
    glyph = '0;
    unique case (digit_i)
      4'd0:    glyph = {5'h00, 5'h0E, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h0E};
      4'd1:    glyph = {5'h00, 5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0C, 5'h04};
      4'd2:    glyph = {5'h00, 5'h1F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      4'd3:    glyph = {5'h00, 5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h02, 5'h1F};
      4'd4:    glyph = {5'h00, 5'h02, 5'h02, 5'h1F, 5'h12, 5'h0A, 5'h06, 5'h02};
      4'd5:    glyph = {5'h00, 5'h0E, 5'h11, 5'h01, 5'h01, 5'h1E, 5'h10, 5'h1F};
      4'd6:    glyph = {5'h00, 5'h0E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h08, 5'h06};
      4'd7:    glyph = {5'h00, 5'h08, 5'h08, 5'h08, 5'h04, 5'h02, 5'h01, 5'h1F};
      4'd8:    glyph = {5'h00, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'd9:    glyph = {5'h00, 5'h0C, 5'h02, 5'h01, 5'h0F, 5'h11, 5'h11, 5'h0E};
      default: glyph = '0;
    endcase
    bits_o = glyph[row_i];
  end

endmodule

// File: rtl/temp_overlay_renderer.sv
// Renders NUM_CH decimal values as coloured digit glyphs; values are converted to BCD by a
// sequential shift-add-3 engine into a work bank and published to the display bank atomically.
// Optional macro TEMP_OVERLAY_BLINK_EN: blink channels whose value is >= ALARM_THR.
module temp_overlay_renderer
  import overlay_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned VAL_W       = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned TEXT_ROW    = 5,
  parameter int unsigned COL0        = 6,
  parameter int unsigned CH_PITCH    = 30,
  parameter int unsigned DIGIT_PITCH = 6,
  parameter int unsigned ALARM_THR   = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*VAL_W-1:0] val_in,
  input  logic                    val_load,
  output logic                    busy,
  input  logic                    frame_tick,
  input  logic                    pix_req,
  input  logic [10:0]             pixel_addr,
  output logic                    pix_valid,
  output logic [23:0]             pixel_data
);

  // Enough BCD digits to hold any VAL_W-bit value, and at least DIGITS.
  localparam int unsigned BCD_N = ((VAL_W + 2) / 3 > DIGITS) ? (VAL_W + 2) / 3 : DIGITS;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  conv_state_e state_q, state_d;
  logic do_load, do_shift, do_store, do_commit;

  logic [NUM_CH*VAL_W-1:0] que_q, pend_val_q, load_val, que_nxt;
  logic                    pend_q;
  logic [VAL_W-1:0]        sh_q;
  logic [BCD_N-1:0][3:0]   bcd_q, bcd_adj, bcd_nxt;
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              ch_q;
  logic                    sat;
  logic [DIGITS-1:0][3:0]  st_dig;
  logic [NUM_CH-1:0][DIGITS-1:0][3:0] work_q, disp_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (val_load) state_d = StShift;
      StShift:  if (cnt_q == CNT_W'(VAL_W - 1)) state_d = StStore;
      StStore:  state_d = (ch_q == 2'(NUM_CH - 1)) ? StCommit : StShift;
      StCommit: state_d = (pend_q || val_load) ? StShift : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs; a load arriving during COMMIT is taken directly as the restart value.
  always_comb begin
    busy      = (state_q != StIdle);
    do_shift  = (state_q == StShift);
    do_store  = (state_q == StStore);
    do_commit = (state_q == StCommit);
    do_load   = ((state_q == StIdle) && val_load) || (do_commit && (pend_q || val_load));
    load_val  = ((state_q == StIdle) || val_load) ? val_in : pend_val_q;
  end

  // Shift-add-3 step, saturation detect and digit reorder (index 0 = most significant).
  always_comb begin
    for (int k = 0; k < BCD_N; k++) begin
      bcd_adj[k] = (bcd_q[k] >= 4'd5) ? bcd_q[k] + 4'd3 : bcd_q[k];
    end
    bcd_nxt[0] = {bcd_adj[0][2:0], sh_q[VAL_W-1]};
    for (int k = 1; k < BCD_N; k++) begin
      bcd_nxt[k] = {bcd_adj[k][2:0], bcd_adj[k-1][3]};
    end
    sat = 1'b0;
    for (int k = DIGITS; k < BCD_N; k++) begin
      sat = sat | (bcd_q[k] != 4'd0);
    end
    for (int d = 0; d < DIGITS; d++) begin
      st_dig[d] = sat ? 4'd9 : bcd_q[DIGITS-1-d];
    end
    que_nxt = que_q >> VAL_W;
  end

`ifdef TEMP_OVERLAY_BLINK_EN
  logic [NUM_CH*VAL_W-1:0] snap_q;
  logic [NUM_CH-1:0]       alarm_q;
  logic [4:0]              blink_cnt_q;

  // Frame counter and per-channel alarm flags taken from the committed snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q      <= '0;
      alarm_q     <= '0;
      blink_cnt_q <= '0;
    end else begin
      if (frame_tick) blink_cnt_q <= blink_cnt_q + 5'd1;
      if (do_commit) begin
        for (int c = 0; c < NUM_CH; c++) begin
          alarm_q[c] <= (32'(snap_q[c*VAL_W +: VAL_W]) >= ALARM_THR);
        end
      end
      if (do_load) snap_q <= load_val;
    end
  end
`else
  localparam int unsigned unused_alarm_thr = ALARM_THR;
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
`endif

  // Conversion datapath, pending load capture and committed display bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      que_q      <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
      work_q     <= '0;
      disp_q     <= '0;
    end else begin
      if (val_load && (do_shift || do_store)) begin
        pend_val_q <= val_in;
        pend_q     <= 1'b1;
      end
      if (do_commit) begin
        pend_q <= 1'b0;
        disp_q <= work_q;
      end
      if (do_load) begin
        que_q <= load_val;
        sh_q  <= load_val[VAL_W-1:0];
        bcd_q <= '0;
        cnt_q <= '0;
        ch_q  <= '0;
      end else if (do_shift) begin
        bcd_q <= bcd_nxt;
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q + 1'b1;
      end else if (do_store) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_q == 2'(c)) work_q[c] <= st_dig;
        end
        ch_q  <= ch_q + 2'd1;
        que_q <= que_nxt;
        sh_q  <= que_nxt[VAL_W-1:0];
        bcd_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  int          row_i, col_i;
  logic        hit_d, mark_d, hide_d;
  logic [1:0]  ch_d;
  logic [3:0]  code_d;
  logic [2:0]  frow_d, xoff_d;

  // Pixel address decode against the committed bank, with leading-zero blanking.
  always_comb begin
    int   base;
    int   x0;
    logic lz;
    logic blank;
    row_i  = int'(pixel_addr[10:6]);
    col_i  = int'(pixel_addr[5:0]);
    hit_d  = 1'b0;
    mark_d = 1'b0;
    hide_d = 1'b0;
    ch_d   = '0;
    code_d = 4'hF;
    xoff_d = '0;
    frow_d = 3'(row_i - int'(TEXT_ROW));
    base   = 0;
    x0     = 0;
    lz     = 1'b1;
    blank  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      base = int'(COL0) + c * int'(CH_PITCH);
      lz   = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
        x0    = base + d * int'(DIGIT_PITCH);
        blank = lz && (disp_q[c][d] == 4'd0) && (d != DIGITS - 1);
        lz    = lz && (disp_q[c][d] == 4'd0);
        if (row_i >= int'(TEXT_ROW) && row_i < int'(TEXT_ROW + GLYPH_H) &&
            col_i >= x0 && col_i < x0 + int'(GLYPH_W)) begin
          hit_d  = 1'b1;
          ch_d   = 2'(c);
          code_d = blank ? 4'hF : disp_q[c][d];
          xoff_d = 3'(col_i - x0);
`ifdef TEMP_OVERLAY_BLINK_EN
          hide_d = blink_cnt_q[4] & alarm_q[c];
`endif
        end
      end
      x0 = base + int'(DIGITS * DIGIT_PITCH);
      if (row_i >= int'(TEXT_ROW) && row_i < int'(TEXT_ROW + MARK_H) &&
          col_i >= x0 && col_i < x0 + int'(MARK_W)) begin
        hit_d  = 1'b1;
        mark_d = 1'b1;
        ch_d   = 2'(c);
`ifdef TEMP_OVERLAY_BLINK_EN
        hide_d = blink_cnt_q[4] & alarm_q[c];
`endif
      end
    end
  end

  logic       s1_valid, s1_hit, s1_mark;
  logic [1:0] s1_ch;
  logic [3:0] s1_code;
  logic [2:0] s1_frow, s1_xoff;
  logic [4:0] font_bits;
  logic       pix_on;

  // Stage 1: register the decoded glyph position and font row.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_mark  <= 1'b0;
      s1_ch    <= '0;
      s1_code  <= 4'hF;
      s1_frow  <= '0;
      s1_xoff  <= '0;
    end else begin
      s1_valid <= pix_req;
      s1_hit   <= pix_req & hit_d & ~hide_d;
      s1_mark  <= mark_d;
      s1_ch    <= ch_d;
      s1_code  <= code_d;
      s1_frow  <= frow_d;
      s1_xoff  <= xoff_d;
    end
  end

  overlay_font_rom u_font (
    .digit_i (s1_code),
    .row_i   (s1_frow),
    .bits_o  (font_bits)
  );

  assign pix_on = s1_hit & (s1_mark | font_bits[3'd4 - s1_xoff]);

  // Stage 2: register the final colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pixel_data <= 24'h000000;
    end else begin
      pix_valid  <= s1_valid;
      pixel_data <= pix_on ? CH_COLOR[s1_ch] : 24'h000000;
    end
  end

endmodule

// File: tb/tb_temp_overlay_renderer.sv
// Directed bench for temp_overlay_renderer: pixel vector table, burst model check and
// multi-cycle conversion sequences; blink checks when TEMP_OVERLAY_BLINK_EN is defined.
module tb_temp_overlay_renderer;

  localparam logic [23:0] RED  = 24'hFF0000;
  localparam logic [23:0] BLUE = 24'h0000FF;
  localparam logic [23:0] BLK  = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val_in = '0;
  logic        val_load = 1'b0;
  logic        busy;
  logic        frame_tick = 1'b0;
  logic        pix_req = 1'b0;
  logic [10:0] pixel_addr = '0;
  logic        pix_valid;
  logic [23:0] pixel_data;

  logic [7:0]  val_in2 = '0;
  logic        val_load2 = 1'b0;
  logic        busy2;
  logic        pix_req2 = 1'b0;
  logic [10:0] pixel_addr2 = '0;
  logic        pix_valid2;
  logic [23:0] pixel_data2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  temp_overlay_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .val_in     (val_in),
    .val_load   (val_load),
    .busy       (busy),
    .frame_tick (frame_tick),
    .pix_req    (pix_req),
    .pixel_addr (pixel_addr),
    .pix_valid  (pix_valid),
    .pixel_data (pixel_data)
  );

  temp_overlay_renderer #(.NUM_CH(1), .DIGITS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .val_in     (val_in2),
    .val_load   (val_load2),
    .busy       (busy2),
    .frame_tick (frame_tick),
    .pix_req    (pix_req2),
    .pixel_addr (pixel_addr2),
    .pix_valid  (pix_valid2),
    .pixel_data (pixel_data2)
  );

  typedef struct {
    int          row;
    int          col;
    logic [23:0] exp;
  } vec_t;

  vec_t        vt [18];
  int          font [10][7];
  int          exp_dig [2][3];
  logic [23:0] ch_col [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_pix(input string name, input int row, input int col,
                           input logic [23:0] exp);
    logic        v;
    logic [23:0] d;
    pix_req    = 1'b1;
    pixel_addr = {5'(row), 6'(col)};
    tick();
    pix_req = 1'b0;
    tick();
    v = pix_valid;
    d = pixel_data;
    chk(name, {7'd0, v, d}, {7'd0, 1'b1, exp});
  endtask

  task automatic check_pix2(input string name, input int row, input int col,
                            input logic [23:0] exp);
    logic        v;
    logic [23:0] d;
    pix_req2    = 1'b1;
    pixel_addr2 = {5'(row), 6'(col)};
    tick();
    pix_req2 = 1'b0;
    tick();
    v = pix_valid2;
    d = pixel_data2;
    chk(name, {7'd0, v, d}, {7'd0, 1'b1, exp});
  endtask

  task automatic load_wait(input logic [15:0] v, output int cnt);
    val_in   = v;
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  // Reference pixel model for the default two-channel, three-digit layout.
  function automatic logic [23:0] model(input int row, input int col);
    int base;
    int x0;
    int dv;
    bit lz;
    for (int c = 0; c < 2; c++) begin
      base = 6 + c * 30;
      lz   = 1'b1;
      for (int d = 0; d < 3; d++) begin
        dv = exp_dig[c][d];
        x0 = base + d * 6;
        if (row >= 5 && row < 12 && col >= x0 && col < x0 + 5) begin
          if (lz && dv == 0 && d < 2) return BLK;
          return ((font[dv][row-5] >> (4 - (col - x0))) & 1) != 0 ? ch_col[c] : BLK;
        end
        if (dv != 0) lz = 1'b0;
      end
      if (row >= 5 && row < 8 && col >= base + 18 && col < base + 20) return ch_col[c];
    end
    return BLK;
  endfunction

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          nb;
    int          pulses;
    int          arow [64];
    int          acol [64];
    bit          exp_v;
    logic [23:0] e;

    font[0] = '{'h0E, 'h11, 'h13, 'h15, 'h19, 'h11, 'h0E};
    font[1] = '{'h04, 'h0C, 'h04, 'h04, 'h04, 'h04, 'h0E};
    font[2] = '{'h1E, 'h01, 'h01, 'h0E, 'h10, 'h10, 'h1F};
    font[3] = '{'h1F, 'h02, 'h04, 'h02, 'h01, 'h11, 'h0E};
    font[4] = '{'h02, 'h06, 'h0A, 'h12, 'h1F, 'h02, 'h02};
    font[5] = '{'h1F, 'h10, 'h1E, 'h01, 'h01, 'h11, 'h0E};
    font[6] = '{'h06, 'h08, 'h10, 'h1E, 'h11, 'h11, 'h0E};
    font[7] = '{'h1F, 'h01, 'h02, 'h04, 'h08, 'h08, 'h08};
    font[8] = '{'h0E, 'h11, 'h11, 'h0E, 'h11, 'h11, 'h0E};
    font[9] = '{'h0E, 'h11, 'h11, 'h0F, 'h01, 'h02, 'h0C};
    ch_col  = '{RED, BLUE};

    // Display " 25" red and " 77" blue.
    vt[0]  = '{5, 12, RED};   vt[1]  = '{5, 6, BLK};    vt[2]  = '{6, 6, BLK};
    vt[3]  = '{5, 16, BLK};   vt[4]  = '{5, 18, RED};   vt[5]  = '{8, 19, BLK};
    vt[6]  = '{8, 22, RED};   vt[7]  = '{5, 24, RED};   vt[8]  = '{7, 25, RED};
    vt[9]  = '{8, 24, BLK};   vt[10] = '{5, 42, BLUE};  vt[11] = '{11, 44, BLK};
    vt[12] = '{11, 43, BLUE}; vt[13] = '{6, 36, BLK};   vt[14] = '{5, 54, BLUE};
    vt[15] = '{5, 11, BLK};   vt[16] = '{4, 12, BLK};   vt[17] = '{12, 12, BLK};

    // Reset state.
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pixel_data", {8'd0, pixel_data}, 32'd0);
    rst = 1'b0;
    tick();
    check_pix("rst_units_zero", 6, 18, RED);
    check_pix("rst_blank_tens", 6, 12, BLK);
    check_pix("rst_marker", 5, 24, RED);
    check_pix("rst_ch1_zero", 6, 48, BLUE);

    // Basic conversion and vector table.
    load_wait(16'h4D19, cnt);
    chk("busy_cycles_19", cnt, 19);
    for (int i = 0; i < 18; i++) begin
      check_pix($sformatf("vec%0d_r%0d_c%0d", i, vt[i].row, vt[i].col),
                vt[i].row, vt[i].col, vt[i].exp);
    end

    // Back-to-back burst against the model.
    exp_dig = '{'{0, 2, 5}, '{0, 7, 7}};
    for (int i = 0; i < 64; i++) begin
      arow[i] = 5 + (i % 7);
      acol[i] = i;
    end
    pulses = 0;
    for (int t = 0; t < 66; t++) begin
      pix_req    = (t < 64);
      pixel_addr = (t < 64) ? {5'(arow[t]), 6'(acol[t])} : 11'd0;
      tick();
      exp_v = (t >= 1 && t <= 64);
      chk($sformatf("burst_valid_t%0d", t), {31'd0, pix_valid}, {31'd0, exp_v});
      if (pix_valid) pulses++;
      if (exp_v) begin
        e = model(arow[t-1], acol[t-1]);
        chk($sformatf("burst_data_%0d", t - 1), {8'd0, pixel_data}, {8'd0, e});
      end
    end
    pix_req = 1'b0;
    chk("burst_pulses", pulses, 64);

    // Reload while busy: first commit shows {99, 8}, then restart to {10, 3}.
    val_in   = {8'd99, 8'd8};
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == 5) begin
        val_in   = {8'd10, 8'd3};
        val_load = 1'b1;
      end
      if (cnt == 20) begin
        pix_req    = 1'b1;
        pixel_addr = {5'd6, 6'd18};
      end
      if (cnt == 22) begin
        chk("mid_commit_valid", {31'd0, pix_valid}, 32'd1);
        chk("mid_commit_first_value", {8'd0, pixel_data}, {8'd0, RED});
      end
      tick();
      val_load = 1'b0;
      pix_req  = 1'b0;
    end
    chk("reload_busy_38", cnt, 38);
    check_pix("reload_3_row1", 6, 18, BLK);
    check_pix("reload_3_row0", 5, 18, RED);
    check_pix("reload_ch0_blank", 5, 12, BLK);
    check_pix("reload_1_lit", 5, 44, BLUE);
    check_pix("reload_1_dark", 5, 42, BLK);
    check_pix("reload_0_lit", 6, 48, BLUE);
    check_pix("reload_ch1_blank", 6, 36, BLK);

    // Reset during conversion with a pending load outstanding.
    val_in   = 16'h0506;
    val_load = 1'b1;
    tick();
    val_load = 1'b0;
    cnt = 1;
    while (cnt < 7) begin
      if (cnt == 3) begin
        val_in   = 16'h0102;
        val_load = 1'b1;
      end
      tick();
      val_load = 1'b0;
      cnt++;
    end
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) nb++;
    end
    chk("no_pending_after_rst", nb, 0);
    check_pix("rst_mid_row0", 5, 18, BLK);
    check_pix("rst_mid_row1", 6, 18, RED);
    check_pix("rst_mid_ch1_blank", 5, 44, BLK);
    check_pix("rst_mid_ch1_zero", 6, 48, BLUE);

    // Saturation with two digits on the second instance.
    val_in2   = 8'd250;
    val_load2 = 1'b1;
    tick();
    val_load2 = 1'b0;
    cnt = 0;
    while (busy2 && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("sat_busy_10", cnt, 10);
    check_pix2("sat_d0_left", 6, 6, RED);
    check_pix2("sat_d0_right", 6, 10, RED);
    check_pix2("sat_d0_row3_on", 8, 9, RED);
    check_pix2("sat_d0_row3_off", 8, 6, BLK);
    check_pix2("sat_d1_left", 6, 12, RED);
    check_pix2("sat_marker", 5, 18, RED);

`ifdef TEMP_OVERLAY_BLINK_EN
    load_wait(16'h002D, cnt);
    for (int k = 0; k < 32; k++) begin
      check_pix($sformatf("blink45_tick%0d", k), 6, 18, (k >= 16) ? BLK : RED);
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
    end
    load_wait(16'h0027, cnt);
    for (int k = 0; k < 32; k++) begin
      check_pix($sformatf("blink39_tick%0d", k), 6, 18, RED);
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
